// File: rtl/lcd_ctrl.sv
// HD44780-style write driver behind the io_lcd register: each START rising edge becomes one
// timed RS/DB/EN write cycle, with an optional power-up init sequence and a one-deep pending slot.
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned PW_CYC        = 12,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned EXEC_LONG_CYC = 80000,
    parameter int unsigned PWRUP_CYC     = 750000,
    parameter bit          INIT_EN       = 1'b1,
    parameter int unsigned CNT_W         = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_cmd_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ovf_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_IDLE  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_EXEC  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_SETUP     = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PW        = CNT_W'(PW_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD      = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_EXEC      = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] C_EXEC_LONG = CNT_W'(EXEC_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] C_PWRUP     = CNT_W'(PWRUP_CYC - 1);
    localparam state_t           S_RESET     = INIT_EN ? S_PWRUP : S_IDLE;
    // The power-up wait is preloaded at reset so PWRUP counts its full length.
    localparam logic [CNT_W-1:0] C_RESET_CNT = INIT_EN ? C_PWRUP : {CNT_W{1'b0}};

    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [7:0]       r_data, w_data_n;
    logic             r_rs, w_rs_n;
    logic             r_en, w_en_n;
    logic             r_done, w_done_n;
    logic             r_ovf, w_ovf_n;
    logic             r_pend, w_pend_n;
    logic [7:0]       r_pend_data, w_pend_data_n;
    logic             r_pend_rs, w_pend_rs_n;
    logic [1:0]       r_init_idx, w_init_idx_n;
    logic             r_in_init, w_in_init_n;
    logic             r_user, w_user_n;
    logic             r_start_q;
    logic             r_armed;
    logic             r_on;

    logic             w_rise;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_direct;
    logic             w_svc_pend;
    logic             w_long;
    logic             w_unused;

    // r_armed masks the first edge after reset so a START left high is not a new command.
    assign w_rise     = lcd_cmd_i[10] & ~r_start_q & r_armed;
    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});
    assign w_cnt_dec  = r_cnt - 1'b1;
    assign w_direct   = (r_state == S_IDLE) && !r_pend;
    assign w_svc_pend = (r_state == S_IDLE) && r_pend;
    assign w_long     = !r_rs && (r_data[7:2] == 6'd0);
    assign w_unused   = ^{lcd_cmd_i[30:11], lcd_cmd_i[9]};

    function automatic logic [7:0] init_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    init_entry = 8'h38;
            2'd1:    init_entry = 8'h0C;
            2'd2:    init_entry = 8'h01;
            default: init_entry = 8'h06;
        endcase
    endfunction

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_data_n      = r_data;
        w_rs_n        = r_rs;
        w_en_n        = r_en;
        w_done_n      = 1'b0;
        w_ovf_n       = r_ovf;
        w_pend_n      = r_pend;
        w_pend_data_n = r_pend_data;
        w_pend_rs_n   = r_pend_rs;
        w_init_idx_n  = r_init_idx;
        w_in_init_n   = r_in_init;
        w_user_n      = r_user;

        case (r_state)
            S_PWRUP: begin
                if (w_cnt_zero) begin
                    w_state_n    = S_SETUP;
                    w_cnt_n      = C_SETUP;
                    w_data_n     = init_entry(2'd0);
                    w_rs_n       = 1'b0;
                    w_init_idx_n = 2'd0;
                    w_in_init_n  = 1'b1;
                    w_user_n     = 1'b0;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            S_IDLE: begin
                if (r_pend) begin
                    w_state_n   = S_SETUP;
                    w_cnt_n     = C_SETUP;
                    w_data_n    = r_pend_data;
                    w_rs_n      = r_pend_rs;
                    w_pend_n    = 1'b0;
                    w_in_init_n = 1'b0;
                    w_user_n    = 1'b1;
                end else if (w_rise) begin
                    w_state_n   = S_SETUP;
                    w_cnt_n     = C_SETUP;
                    w_data_n    = lcd_cmd_i[7:0];
                    w_rs_n      = lcd_cmd_i[8];
                    w_in_init_n = 1'b0;
                    w_user_n    = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_n = S_PULSE;
                    w_cnt_n   = C_PW;
                    w_en_n    = 1'b1;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            S_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_n = S_HOLD;
                    w_cnt_n   = C_HOLD;
                    w_en_n    = 1'b0;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_n = S_EXEC;
                    w_cnt_n   = w_long ? C_EXEC_LONG : C_EXEC;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            S_EXEC: begin
                if (!w_cnt_zero) begin
                    w_cnt_n = w_cnt_dec;
                end else if (r_in_init && (r_init_idx != 2'd3)) begin
                    w_init_idx_n = r_init_idx + 2'd1;
                    w_data_n     = init_entry(w_init_idx_n);
                    w_rs_n       = 1'b0;
                    w_state_n    = S_SETUP;
                    w_cnt_n      = C_SETUP;
                end else begin
                    w_state_n   = S_IDLE;
                    w_done_n    = r_user;
                    w_in_init_n = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // A rise the controller cannot start right now goes to the pending slot; the slot
        // is free again in the cycle IDLE drains it.
        if (w_rise && !w_direct) begin
            if (!r_pend || w_svc_pend) begin
                w_pend_n      = 1'b1;
                w_pend_data_n = lcd_cmd_i[7:0];
                w_pend_rs_n   = lcd_cmd_i[8];
            end else begin
                w_ovf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_RESET;
            r_cnt       <= C_RESET_CNT;
            r_data      <= 8'd0;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_data <= 8'd0;
            r_pend_rs   <= 1'b0;
            r_init_idx  <= 2'd0;
            r_in_init   <= 1'b0;
            r_user      <= 1'b0;
            r_start_q   <= 1'b0;
            r_armed     <= 1'b0;
            r_on        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_data      <= w_data_n;
            r_rs        <= w_rs_n;
            r_en        <= w_en_n;
            r_done      <= w_done_n;
            r_ovf       <= w_ovf_n;
            r_pend      <= w_pend_n;
            r_pend_data <= w_pend_data_n;
            r_pend_rs   <= w_pend_rs_n;
            r_init_idx  <= w_init_idx_n;
            r_in_init   <= w_in_init_n;
            r_user      <= w_user_n;
            r_start_q   <= lcd_cmd_i[10];
            r_armed     <= 1'b1;
            r_on        <= lcd_cmd_i[31];
        end
    end

    assign lcd_data_o  = r_data;
    assign lcd_rs_o    = r_rs;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = r_en;
    assign lcd_on_o    = r_on;
    assign busy_o      = (r_state != S_IDLE) || r_pend;
    assign done_o      = r_done;
    assign ovf_o       = r_ovf;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: a transaction-level schedule model predicts EN pulse times, bytes and done
// pulses; dut0 runs without init, dut1 with a short power-up init sequence.
module tb_lcd_ctrl;

    localparam int SETUP = 2, PW = 4, HOLD = 2, EXEC = 10, EXEC_LONG = 30, PWRUP = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst1_n;
    logic [31:0] cmd0, cmd1;
    logic [7:0]  data0, data1;
    logic        rs0, rs1, rw0, rw1, en0, en1, on0, on1;
    logic        busy0, busy1, done0, done1, ovf0, ovf1;
    logic [2:0]  st0, st1;

    lcd_ctrl #(.SETUP_CYC(SETUP), .PW_CYC(PW), .HOLD_CYC(HOLD), .EXEC_CYC(EXEC),
               .EXEC_LONG_CYC(EXEC_LONG), .PWRUP_CYC(PWRUP), .INIT_EN(1'b0), .CNT_W(20)) dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .lcd_cmd_i(cmd0), .lcd_data_o(data0), .lcd_rs_o(rs0),
        .lcd_rw_o(rw0), .lcd_en_o(en0), .lcd_on_o(on0), .busy_o(busy0), .done_o(done0),
        .ovf_o(ovf0), .dbg_state_o(st0));

    lcd_ctrl #(.SETUP_CYC(SETUP), .PW_CYC(PW), .HOLD_CYC(HOLD), .EXEC_CYC(EXEC),
               .EXEC_LONG_CYC(EXEC_LONG), .PWRUP_CYC(PWRUP), .INIT_EN(1'b1), .CNT_W(20)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .lcd_cmd_i(cmd1), .lcd_data_o(data1), .lcd_rs_o(rs1),
        .lcd_rw_o(rw1), .lcd_en_o(en1), .lcd_on_o(on1), .busy_o(busy1), .done_o(done1),
        .ovf_o(ovf1), .dbg_state_o(st1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected EN pulses: {edge of EN rise, rs, data}; expected done pulses: edge index.
    logic [40:0] exp_en_q0[$], exp_en_q1[$];
    logic [31:0] exp_done_q0[$], exp_done_q1[$];
    int          m_last_start[2];
    int          m_last_end[2];
    logic        m_ovf[2];
    logic        en_prev[2];
    int          en_w[2];
    logic [7:0]  init_b[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dur(input logic [7:0] d, input logic rs);
        return SETUP + PW + HOLD + ((!rs && d[7:2] == 6'd0) ? EXEC_LONG : EXEC);
    endfunction

    // Commands run back to back in arrival order; one may wait, anything beyond that is dropped.
    task automatic model_rise(input int id, input int t, input logic [7:0] d, input logic rs);
        int s;
        logic [40:0] e;
        if (m_last_start[id] > t) begin
            m_ovf[id] = 1'b1;
            return;
        end
        s = (t > m_last_end[id]) ? t : m_last_end[id] + 1;
        m_last_start[id] = s;
        m_last_end[id] = s + dur(d, rs);
        e = {32'(s + SETUP), rs, d};
        if (id == 0) begin
            exp_en_q0.push_back(e);
            exp_done_q0.push_back(32'(m_last_end[id]));
        end else begin
            exp_en_q1.push_back(e);
            exp_done_q1.push_back(32'(m_last_end[id]));
        end
    endtask

    task automatic model_init(input int p);
        int s;
        s = p + PWRUP;
        for (int k = 0; k < 4; k++) begin
            exp_en_q1.push_back({32'(s + SETUP), 1'b0, init_b[k]});
            s = s + dur(init_b[k], 1'b0);
        end
        m_last_start[1] = -1000;
        m_last_end[1] = s;
    endtask

    task automatic mon(input int id, input logic en, input logic [7:0] d, input logic rs,
                       input logic done);
        logic [40:0] e;
        logic [31:0] de;
        int n_en, n_done;
        n_en = (id == 0) ? exp_en_q0.size() : exp_en_q1.size();
        n_done = (id == 0) ? exp_done_q0.size() : exp_done_q1.size();
        if (en && !en_prev[id]) begin
            en_w[id] = 1;
            chk("en_was_expected", 32'(n_en > 0), 32'd1);
            if (n_en > 0) begin
                if (id == 0) e = exp_en_q0.pop_front(); else e = exp_en_q1.pop_front();
                chk("en_rise_cycle", 32'(cyc), e[40:9]);
                chk("en_rs_byte", {23'd0, rs, d}, {23'd0, e[8:0]});
            end
        end else if (en) begin
            en_w[id] = en_w[id] + 1;
        end else if (en_prev[id]) begin
            chk("en_width", 32'(en_w[id]), 32'(PW));
        end
        en_prev[id] = en;
        if (done) begin
            chk("done_was_expected", 32'(n_done > 0), 32'd1);
            if (n_done > 0) begin
                if (id == 0) de = exp_done_q0.pop_front(); else de = exp_done_q1.pop_front();
                chk("done_cycle", 32'(cyc), de);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, en0, data0, rs0, done0);
        mon(1, en1, data1, rs1, done1);
    end

    task automatic pulse(input int id, input logic [7:0] d, input logic rs, input int hi,
                         input logic rnd);
        logic on_b;
        logic [31:0] c;
        on_b = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        c = rnd ? {on_b, 20'($urandom), 1'b1, 1'($urandom), rs, d}
                : {21'd0, 1'b1, 1'b0, rs, d};
        @(negedge clk);
        if (id == 0) cmd0 = c; else cmd1 = c;
        model_rise(id, cyc + 1, d, rs);
        @(negedge clk);
        chk("lcd_on", 32'((id == 0) ? on0 : on1), 32'(on_b));
        chk("ovf_track", 32'((id == 0) ? ovf0 : ovf1), 32'(m_ovf[id]));
        repeat (hi - 1) @(negedge clk);
        if (id == 0) cmd0[10] = 1'b0; else cmd1[10] = 1'b0;
    endtask

    task automatic drain(input int id, input int budget);
        int k;
        k = 0;
        while (k < budget && ((id == 0) ? (exp_en_q0.size() + exp_done_q0.size())
                                        : (exp_en_q1.size() + exp_done_q1.size())) != 0) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_budget", 32'(k < budget), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int p, k, low_cnt, init_end;
        logic [7:0] d;
        logic rs;
        m_last_start = '{-1000, -1000};
        m_last_end = '{-1000, -1000};
        m_ovf = '{1'b0, 1'b0};
        en_prev = '{1'b0, 1'b0};
        en_w = '{0, 0};
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        cmd0 = 32'd0;
        cmd1 = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(en0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_rs", 32'(rs0), 32'd0);
        chk("rst_rw", 32'(rw0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_en_init", 32'(en1), 32'd0);

        // Init sequence with a user command arriving mid-init
        @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        p = cyc;
        model_init(p);
        init_end = m_last_end[1];
        low_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy1) low_cnt++;
        end
        pulse(1, 8'h5A, 1'b1, 1, 1'b0);
        while (cyc < init_end) begin
            @(negedge clk);
            if (!busy1) low_cnt++;
        end
        chk("init_busy_low_cycles", 32'(low_cnt), 32'd0);
        drain(1, 400);
        chk("init_busy_after", 32'(busy1), 32'd0);
        chk("init_ovf", 32'(ovf1), 32'd0);

        // Data write 'A'
        pulse(0, 8'h41, 1'b1, 1, 1'b0);
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_data", 32'(data0), 32'h41);
        chk("t1_rs", 32'(rs0), 32'd1);
        drain(0, 100);
        chk("t1_busy_after", 32'(busy0), 32'd0);
        chk("t1_data_hold", 32'(data0), 32'h41);

        // Clear display (long execute)
        pulse(0, 8'h01, 1'b0, 2, 1'b0);
        chk("t2_rs", 32'(rs0), 32'd0);
        drain(0, 100);

        // Back-to-back
        pulse(0, 8'h48, 1'b1, 1, 1'b0);
        repeat (3) @(negedge clk);
        pulse(0, 8'h49, 1'b1, 2, 1'b0);
        drain(0, 100);
        chk("t3_ovf", 32'(ovf0), 32'd0);

        // Overflow: pending slot full, third command dropped
        pulse(0, 8'h30, 1'b1, 1, 1'b0);
        repeat (2) @(negedge clk);
        pulse(0, 8'h31, 1'b1, 1, 1'b0);
        repeat (2) @(negedge clk);
        pulse(0, 8'h32, 1'b1, 1, 1'b0);
        drain(0, 100);
        chk("t4_ovf", 32'(ovf0), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rs = ($urandom_range(0, 3) != 0);
            d = 8'($urandom_range(0, 255));
            if (!rs && $urandom_range(0, 1) == 1) d[7:2] = 6'd0;
            pulse(0, d, rs, $urandom_range(1, 3), 1'b1);
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        drain(0, 3000);
        chk("rand_ovf_sticky", 32'(ovf0), 32'(m_ovf[0]));

        // Reset while EN is high, START left high through release
        @(negedge clk);
        cmd0 = 32'h0000_0541;
        model_rise(0, cyc + 1, 8'h41, 1'b1);
        k = 0;
        while (!en0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach_pulse", 32'(en0), 32'd1);
        @(posedge clk);
        #2;
        rst0_n = 1'b0;
        #1;
        chk("t6_en", 32'(en0), 32'd0);
        chk("t6_busy", 32'(busy0), 32'd0);
        chk("t6_data", 32'(data0), 32'd0);
        chk("t6_done", 32'(done0), 32'd0);
        chk("t6_ovf", 32'(ovf0), 32'd0);
        en_prev[0] = 1'b0;
        exp_en_q0.delete();
        exp_done_q0.delete();
        m_last_start[0] = -1000;
        m_last_end[0] = -1000;
        m_ovf[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_idle_busy", 32'(busy0), 32'd0);
        chk("t6_idle_data", 32'(data0), 32'd0);
        cmd0 = 32'd0;
        pulse(0, 8'h55, 1'b1, 1, 1'b0);
        drain(0, 100);
        chk("t6_recover_busy", 32'(busy0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
